// File: rtl/audio_pkg.sv
// Shared audio-path types and widths used by the impulse convolver slice.
package audio_pkg;

    localparam int unsigned SAMPLE_W       = 16;
    localparam int unsigned IMPULSE_ADDR_W = 16;

    typedef enum logic [2:0] {
        CLEAR,
        IDLE,
        MAC,
        DRAIN,
        OUTPUT
    } conv_state_t;

endpackage

// File: rtl/impulse_convolver_if.sv
// Sample stream and impulse BRAM read port of the impulse convolver.
interface impulse_convolver_if;
    import audio_pkg::*;

    logic                        audio_trigger;
    logic signed [SAMPLE_W-1:0]  audio_in;
    logic signed [SAMPLE_W-1:0]  audio_out;
    logic                        audio_out_valid;
    logic [IMPULSE_ADDR_W-1:0]   read_addr;
    logic signed [SAMPLE_W-1:0]  read_data;

    modport master (
        output audio_trigger, audio_in, read_data,
        input  audio_out, audio_out_valid, read_addr
    );

    modport slave (
        input  audio_trigger, audio_in, read_data,
        output audio_out, audio_out_valid, read_addr
    );
endinterface

// File: rtl/sample_history_ram.sv
// Simple dual-port sample history RAM, registered output (2-cycle read latency).
module sample_history_ram
    import audio_pkg::*;
#(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned ADDR_W = 10
) (
    input  logic                       audio_clk,
    input  logic                       we,
    input  logic [ADDR_W-1:0]          waddr,
    input  logic signed [SAMPLE_W-1:0] wdata,
    input  logic [ADDR_W-1:0]          raddr,
    output logic signed [SAMPLE_W-1:0] rdata
);

    logic signed [SAMPLE_W-1:0] mem [DEPTH];
    logic signed [SAMPLE_W-1:0] rd_q;

    always_ff @(posedge audio_clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rd_q  <= mem[raddr];
        rdata <= rd_q;
    end

endmodule

// File: rtl/impulse_convolver.sv
// FIR convolution of live audio against the recorded impulse held in the impulse BRAM.
// Define IMPULSE_CONVOLVER_SATURATE_EN to clamp the output instead of wrapping it.
module impulse_convolver
    import audio_pkg::*;
#(
    parameter int unsigned NUM_TAPS  = 1024,
    parameter int unsigned OUT_SHIFT = 15
) (
    input  logic                audio_clk,
    input  logic                rst_in,
    input  logic                impulse_ready,
    impulse_convolver_if.slave  conv_bus,
    output logic                busy,
    output logic                overrun
);

    localparam int unsigned TAP_W  = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam int unsigned PROD_W = 2 * SAMPLE_W;
    localparam int unsigned ACC_W  = PROD_W + TAP_W;
    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NUM_TAPS - 1);

    conv_state_t                state;
    logic [TAP_W-1:0]           head;
    logic [TAP_W-1:0]           tap;
    logic [TAP_W-1:0]           clr_cnt;
    logic [1:0]                 drain_cnt;
    logic [1:0]                 mac_v;
    logic                       prod_v;
    logic signed [PROD_W-1:0]   prod;
    logic signed [ACC_W-1:0]    acc;

    logic                       hist_we_c;
    logic [TAP_W-1:0]           hist_waddr_c;
    logic signed [SAMPLE_W-1:0] hist_wdata_c;
    logic [TAP_W-1:0]           hist_raddr_c;
    logic signed [SAMPLE_W-1:0] hist_rdata;
    logic signed [ACC_W-1:0]    acc_shift_c;
    logic signed [SAMPLE_W-1:0] result_c;

    // Single write port: zero fill during CLEAR, otherwise the accepted sample at head.
    always_comb begin
        hist_we_c    = 1'b0;
        hist_waddr_c = head;
        hist_wdata_c = conv_bus.audio_in;
        if (!rst_in) begin
            if (state == CLEAR) begin
                hist_we_c    = 1'b1;
                hist_waddr_c = clr_cnt;
                hist_wdata_c = '0;
            end else if (state == IDLE && conv_bus.audio_trigger) begin
                hist_we_c = 1'b1;
            end
        end
    end

    assign hist_raddr_c = head - tap;

    sample_history_ram #(
        .DEPTH  (NUM_TAPS),
        .ADDR_W (TAP_W)
    ) u_history (
        .audio_clk (audio_clk),
        .we        (hist_we_c),
        .waddr     (hist_waddr_c),
        .wdata     (hist_wdata_c),
        .raddr     (hist_raddr_c),
        .rdata     (hist_rdata)
    );

`ifdef IMPULSE_CONVOLVER_SATURATE_EN
    localparam logic signed [ACC_W-1:0]    ACC_HI  = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0]    ACC_LO  = ACC_W'(-32768);
    localparam logic signed [SAMPLE_W-1:0] OUT_MAX = SAMPLE_W'(32767);
    localparam logic signed [SAMPLE_W-1:0] OUT_MIN = SAMPLE_W'(-32768);

    always_comb begin
        acc_shift_c = acc >>> OUT_SHIFT;
        result_c    = SAMPLE_W'(acc_shift_c);
        if (acc_shift_c > ACC_HI) begin
            result_c = OUT_MAX;
        end else if (acc_shift_c < ACC_LO) begin
            result_c = OUT_MIN;
        end
    end
`else
    always_comb begin
        acc_shift_c = acc >>> OUT_SHIFT;
        result_c    = SAMPLE_W'(acc_shift_c);
    end
`endif

    // Taps enter at MAC, data returns 2 cycles later from both RAMs, product is
    // registered, then accumulated; DRAIN covers those four trailing cycles.
    always_ff @(posedge audio_clk) begin
        conv_bus.audio_out_valid <= 1'b0;
        if (rst_in) begin
            state             <= CLEAR;
            clr_cnt           <= '0;
            head              <= '0;
            tap               <= '0;
            drain_cnt         <= '0;
            mac_v             <= '0;
            prod_v            <= 1'b0;
            prod              <= '0;
            acc               <= '0;
            conv_bus.audio_out <= '0;
            conv_bus.read_addr <= '0;
            busy              <= 1'b1;
            overrun           <= 1'b0;
        end else begin
            mac_v  <= {mac_v[0], state == MAC};
            prod_v <= mac_v[1];
            prod   <= PROD_W'(hist_rdata) * PROD_W'(conv_bus.read_data);
            if (prod_v) begin
                acc <= acc + ACC_W'(prod);
            end
            if (conv_bus.audio_trigger && busy && state != CLEAR) begin
                overrun <= 1'b1;
            end

            case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + TAP_W'(1);
                    if (clr_cnt == LAST_TAP) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                IDLE: begin
                    if (conv_bus.audio_trigger) begin
                        if (impulse_ready) begin
                            state              <= MAC;
                            busy               <= 1'b1;
                            tap                <= '0;
                            conv_bus.read_addr <= '0;
                            acc                <= '0;
                        end else begin
                            conv_bus.audio_out       <= conv_bus.audio_in;
                            conv_bus.audio_out_valid <= 1'b1;
                            head                     <= head + TAP_W'(1);
                        end
                    end
                end
                MAC: begin
                    if (tap == LAST_TAP) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                    end else begin
                        tap                <= tap + TAP_W'(1);
                        conv_bus.read_addr <= IMPULSE_ADDR_W'(tap) + IMPULSE_ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt + 2'd1;
                    if (drain_cnt == 2'd3) begin
                        state                    <= OUTPUT;
                        conv_bus.audio_out       <= result_c;
                        conv_bus.audio_out_valid <= 1'b1;
                    end
                end
                OUTPUT: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    head  <= head + TAP_W'(1);
                end
                default: begin
                    state   <= CLEAR;
                    clr_cnt <= '0;
                    busy    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_impulse_convolver.sv
// Self-checking bench for impulse_convolver: directed scenarios plus randomized samples
// checked against a direct FIR sum over the sample history since reset.
module tb_impulse_convolver;
    import audio_pkg::*;

    localparam int unsigned TAPS     = 8;
    localparam int unsigned SHIFT    = 14;
    localparam int          CONV_LAT = TAPS + 5;

    logic audio_clk = 1'b0;
    logic rst_in;
    logic impulse_ready;
    logic busy;
    logic overrun;

    impulse_convolver_if bus ();

    impulse_convolver #(
        .NUM_TAPS  (TAPS),
        .OUT_SHIFT (SHIFT)
    ) dut (
        .audio_clk     (audio_clk),
        .rst_in        (rst_in),
        .impulse_ready (impulse_ready),
        .conv_bus      (bus),
        .busy          (busy),
        .overrun       (overrun)
    );

    always #5 audio_clk = ~audio_clk;

    // Impulse BRAM model with 2-cycle read latency.
    logic signed [15:0] imp [TAPS];
    logic signed [15:0] rd_q;
    always @(posedge audio_clk) begin
        rd_q          <= (bus.read_addr < 16'(TAPS)) ? imp[bus.read_addr[2:0]] : 16'sd0;
        bus.read_data <= rd_q;
    end

    int total;
    int bad;
    int hist[$];

    function automatic logic signed [15:0] model_out();
        longint acc = 0;
        for (int k = 0; k < int'(TAPS); k++) begin
            if (k < hist.size())
                acc += longint'(imp[k]) * longint'(hist[hist.size() - 1 - k]);
        end
        acc = acc >>> SHIFT;
`ifdef IMPULSE_CONVOLVER_SATURATE_EN
        if (acc > 32767) acc = 32767;
        else if (acc < -32768) acc = -32768;
`endif
        return 16'(acc);
    endfunction

    task automatic step();
        @(posedge audio_clk);
        #1;
    endtask

    task automatic do_reset();
        rst_in            = 1'b1;
        bus.audio_trigger = 1'b0;
        step();
        step();
        rst_in = 1'b0;
        hist.delete();
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 40 && busy; i++) step();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL %s wait_idle: busy=%b expected 0", tag, busy);
        end
    endtask

    task automatic set_impulse_random();
        for (int k = 0; k < int'(TAPS); k++) imp[k] = 16'($urandom);
    endtask

    // Trigger one sample; reports output, cycles from trigger to valid, and busy at T+1.
    task automatic send(input logic signed [15:0] s, output logic signed [15:0] got,
                        output int lat, output logic busy1);
        bus.audio_in      = s;
        bus.audio_trigger = 1'b1;
        step();
        bus.audio_trigger = 1'b0;
        busy1 = busy;
        lat   = -1;
        got   = '0;
        for (int i = 1; i <= 40; i++) begin
            if (bus.audio_out_valid) begin
                lat = i;
                got = bus.audio_out;
                break;
            end
            step();
        end
        step();
    endtask

    task automatic test_reset();
        int   cnt;
        logic seen_valid;
        do_reset();
        total++; if (bus.audio_out !== 16'sd0) begin bad++; $display("FAIL reset audio_out: got %0d expected 0", bus.audio_out); end
        total++; if (bus.audio_out_valid !== 1'b0) begin bad++; $display("FAIL reset valid: got %b expected 0", bus.audio_out_valid); end
        total++; if (bus.read_addr !== 16'd0) begin bad++; $display("FAIL reset read_addr: got %0d expected 0", bus.read_addr); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset overrun: got %b expected 0", overrun); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL reset busy: got %b expected 1", busy); end
        cnt        = 0;
        seen_valid = 1'b0;
        impulse_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.audio_trigger = (i == 2);
            bus.audio_in      = 16'sd77;
            if (!busy) break;
            if (bus.audio_out_valid) seen_valid = 1'b1;
            cnt++;
            step();
        end
        bus.audio_trigger = 1'b0;
        total++; if (cnt !== int'(TAPS)) begin bad++; $display("FAIL reset clear_len: got %0d expected %0d", cnt, TAPS); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset clear_trigger overrun: got %b expected 0", overrun); end
        total++; if (seen_valid !== 1'b0) begin bad++; $display("FAIL reset clear_trigger valid: got %b expected 0", seen_valid); end
    endtask

    task automatic test_identity();
        int ins[3] = '{100, -200, 300};
        logic signed [15:0] got, exp;
        int   lat;
        logic b1;
        do_reset();
        wait_idle("identity");
        impulse_ready = 1'b1;
        for (int k = 0; k < int'(TAPS); k++) imp[k] = 16'sd0;
        imp[0] = 16'sd16384;
        for (int i = 0; i < 3; i++) begin
            hist.push_back(ins[i]);
            exp = model_out();
            send(16'(ins[i]), got, lat, b1);
            total++; if (got !== exp) begin bad++; $display("FAIL identity[%0d] out: got %0d expected %0d", i, got, exp); end
            total++; if (got !== 16'(ins[i])) begin bad++; $display("FAIL identity[%0d] passthru: got %0d expected %0d", i, got, ins[i]); end
            total++; if (lat !== CONV_LAT) begin bad++; $display("FAIL identity[%0d] latency: got %0d expected %0d", i, lat, CONV_LAT); end
            total++; if (b1 !== 1'b1) begin bad++; $display("FAIL identity[%0d] busy: got %b expected 1", i, b1); end
        end
    endtask

    task automatic test_delay();
        int tbl[6] = '{0, 0, 0, 1, 2, 3};
        logic signed [15:0] got, exp;
        int   lat;
        logic b1;
        do_reset();
        wait_idle("delay");
        impulse_ready = 1'b1;
        for (int k = 0; k < int'(TAPS); k++) imp[k] = 16'sd0;
        imp[3] = 16'sd16384;
        for (int i = 0; i < 11; i++) begin
            hist.push_back(i + 1);
            exp = model_out();
            send(16'(i + 1), got, lat, b1);
            total++; if (got !== exp) begin bad++; $display("FAIL delay[%0d] out: got %0d expected %0d", i, got, exp); end
            if (i < 6) begin
                total++; if (got !== 16'(tbl[i])) begin bad++; $display("FAIL delay[%0d] table: got %0d expected %0d", i, got, tbl[i]); end
            end
        end
    endtask

    task automatic test_saturation();
        logic signed [15:0] got, exp, fourth;
        int   lat;
        logic b1;
        do_reset();
        wait_idle("saturation");
        impulse_ready = 1'b1;
        for (int k = 0; k < int'(TAPS); k++) imp[k] = (k < 4) ? 16'sd32767 : 16'sd0;
`ifdef IMPULSE_CONVOLVER_SATURATE_EN
        fourth = 16'sd32767;
`else
        fourth = -16'sd16;
`endif
        for (int i = 0; i < 6; i++) begin
            hist.push_back(32767);
            exp = model_out();
            send(16'sd32767, got, lat, b1);
            total++; if (got !== exp) begin bad++; $display("FAIL saturation[%0d] out: got %0d expected %0d", i, got, exp); end
            if (i == 3) begin
                total++; if (got !== fourth) begin bad++; $display("FAIL saturation fourth: got %0d expected %0d", got, fourth); end
            end
        end
    endtask

    task automatic test_bypass();
        logic signed [15:0] got, exp;
        int   lat;
        logic b1;
        do_reset();
        wait_idle("bypass");
        set_impulse_random();
        impulse_ready = 1'b0;
        hist.push_back(-1234);
        send(-16'sd1234, got, lat, b1);
        total++; if (got !== -16'sd1234) begin bad++; $display("FAIL bypass out: got %0d expected -1234", got); end
        total++; if (lat !== 1) begin bad++; $display("FAIL bypass latency: got %0d expected 1", lat); end
        total++; if (b1 !== 1'b0) begin bad++; $display("FAIL bypass busy: got %b expected 0", b1); end
        impulse_ready = 1'b1;
        hist.push_back(555);
        exp = model_out();
        send(16'sd555, got, lat, b1);
        total++; if (got !== exp) begin bad++; $display("FAIL bypass followup out: got %0d expected %0d", got, exp); end
    endtask

    task automatic test_overrun();
        logic signed [15:0] a, b, c, got, exp;
        int   lat;
        logic b1;
        do_reset();
        wait_idle("overrun");
        impulse_ready = 1'b1;
        set_impulse_random();
        a = 16'($urandom);
        b = 16'($urandom);
        hist.push_back(int'(a));
        exp = model_out();
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL overrun pre: got %b expected 0", overrun); end
        bus.audio_in      = a;
        bus.audio_trigger = 1'b1;
        step();
        bus.audio_trigger = 1'b0;
        for (int i = 1; i < 5; i++) step();
        bus.audio_in      = b;
        bus.audio_trigger = 1'b1;
        step();
        bus.audio_trigger = 1'b0;
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL overrun set: got %b expected 1", overrun); end
        lat = -1;
        got = '0;
        for (int i = 6; i <= 40; i++) begin
            if (bus.audio_out_valid) begin
                lat = i;
                got = bus.audio_out;
                break;
            end
            step();
        end
        step();
        total++; if (got !== exp) begin bad++; $display("FAIL overrun first out: got %0d expected %0d", got, exp); end
        total++; if (lat !== CONV_LAT) begin bad++; $display("FAIL overrun latency: got %0d expected %0d", lat, CONV_LAT); end
        c = 16'($urandom);
        hist.push_back(int'(c));
        exp = model_out();
        send(c, got, lat, b1);
        total++; if (got !== exp) begin bad++; $display("FAIL overrun next out: got %0d expected %0d", got, exp); end
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL overrun sticky: got %b expected 1", overrun); end
    endtask

    task automatic test_reset_mid_mac();
        logic signed [15:0] got, exp, c;
        int   lat;
        int   cnt;
        logic b1;
        logic seen_valid;
        do_reset();
        wait_idle("reset_mid_mac");
        set_impulse_random();
        impulse_ready = 1'b0;
        send(16'sd4321, got, lat, b1);
        impulse_ready     = 1'b1;
        bus.audio_in      = 16'($urandom);
        bus.audio_trigger = 1'b1;
        step();
        bus.audio_trigger = 1'b0;
        for (int i = 1; i < 4; i++) step();
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        hist.delete();
        total++; if (bus.audio_out !== 16'sd0) begin bad++; $display("FAIL rst_mac audio_out: got %0d expected 0", bus.audio_out); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rst_mac overrun: got %b expected 0", overrun); end
        cnt        = 0;
        seen_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!busy) break;
            if (bus.audio_out_valid) seen_valid = 1'b1;
            cnt++;
            step();
        end
        total++; if (cnt !== int'(TAPS)) begin bad++; $display("FAIL rst_mac clear_len: got %0d expected %0d", cnt, TAPS); end
        total++; if (seen_valid !== 1'b0) begin bad++; $display("FAIL rst_mac stray valid: got %b expected 0", seen_valid); end
        c = 16'($urandom);
        hist.push_back(int'(c));
        exp = model_out();
        send(c, got, lat, b1);
        total++; if (got !== exp) begin bad++; $display("FAIL rst_mac after out: got %0d expected %0d", got, exp); end
        total++; if (lat !== CONV_LAT) begin bad++; $display("FAIL rst_mac after latency: got %0d expected %0d", lat, CONV_LAT); end
    endtask

    task automatic test_back_to_back();
        logic signed [15:0] s, got, exp;
        int   lat;
        int   want_lat;
        logic b1;
        do_reset();
        wait_idle("back_to_back");
        set_impulse_random();
        for (int i = 0; i < 24; i++) begin
            impulse_ready = ($urandom_range(0, 3) != 0);
            want_lat      = impulse_ready ? CONV_LAT : 1;
            s = 16'($urandom);
            hist.push_back(int'(s));
            exp = model_out();
            if (!impulse_ready) exp = s;
            send(s, got, lat, b1);
            total++; if (got !== exp) begin bad++; $display("FAIL b2b[%0d] out: got %0d expected %0d", i, got, exp); end
            total++; if (lat !== want_lat) begin bad++; $display("FAIL b2b[%0d] latency: got %0d expected %0d", i, lat, want_lat); end
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) step();
        end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL b2b overrun: got %b expected 0", overrun); end
    endtask

    initial begin
        total             = 0;
        bad               = 0;
        rst_in            = 1'b1;
        impulse_ready     = 1'b0;
        bus.audio_trigger = 1'b0;
        bus.audio_in      = '0;
        for (int k = 0; k < int'(TAPS); k++) imp[k] = 16'sd0;
        test_reset();
        test_identity();
        test_delay();
        test_saturation();
        test_bypass();
        test_overrun();
        test_reset_mid_mac();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
